// File: rtl/shiftadder_pkg.sv
// Shared constants and types for the nibble-serial shift-add multiplier.
// Optional build macro: SHIFTADDER_SEQ_EARLY_EXIT_EN (zero-operand fast path).
package shiftadder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } seq_state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_mul_4x4.sv
// Combinational 4x4 shift-add multiplier with per-operand signedness.
// Optional build macro: SHIFTADDER_SEQ_EARLY_EXIT_EN (not used here).
module nibble_mul_4x4
  import shiftadder_pkg::*;
(
  input  logic [NIBBLE_W-1:0]   a,
  input  logic [NIBBLE_W-1:0]   b,
  input  logic                  a_signed,
  input  logic                  b_signed,
  output logic [2*NIBBLE_W-1:0] p
);

  logic [2*NIBBLE_W-1:0] a_ext;
  logic [2*NIBBLE_W-1:0] b_ext;

  // Every 4x4 product (signed or not) fits in 8 bits, so mod-256 is exact.
  always_comb begin
    a_ext = {{NIBBLE_W{a_signed & a[NIBBLE_W-1]}}, a};
    b_ext = {{NIBBLE_W{b_signed & b[NIBBLE_W-1]}}, b};
    p     = '0;
    for (int t = 0; t < 2*NIBBLE_W; t++) begin
      if (b_ext[t]) begin
        p = p + (a_ext << t);
      end
    end
  end

endmodule

// File: rtl/shiftadder_seq_mult.sv
// Sequential WIDTHxWIDTH multiplier iterating one shared 4x4 nibble unit.
// Optional build macro: SHIFTADDER_SEQ_EARLY_EXIT_EN (zero operand -> DONE in 1 cycle).
module shiftadder_seq_mult
  import shiftadder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               op_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = nibble_count(WIDTH);
  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH > 32 || WIDTH < 4) begin : g_bad_width
    $fatal(1, "shiftadder_seq_mult: WIDTH must be a multiple of 4 in 4..32");
  end

  seq_state_e state;
  seq_state_e nxt;
  seq_state_e start_state;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                s_q;
  logic [2*WIDTH-1:0]  acc;
  logic [KW-1:0]       k;
  logic                accept;

  int                  ni;
  int                  nj;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic                a_sg;
  logic                b_sg;
  logic [2*NIBBLE_W-1:0] pp;
  logic [2*WIDTH-1:0]  pp_ext;
  logic [2*WIDTH-1:0]  term;

  assign accept = in_valid & in_ready;

`ifdef SHIFTADDER_SEQ_EARLY_EXIT_EN
  logic zero_op;
  assign zero_op     = (op_a == '0) | (op_b == '0);
  assign start_state = zero_op ? DONE : BUSY;
`else
  assign start_state = BUSY;
`endif

  // k walks op_a nibbles in the outer loop, op_b nibbles in the inner.
  always_comb begin
    ni    = int'(k) / N;
    nj    = int'(k) % N;
    nib_a = NIBBLE_W'(a_q >> (ni * NIBBLE_W));
    nib_b = NIBBLE_W'(b_q >> (nj * NIBBLE_W));
    a_sg  = s_q & (ni == N - 1);
    b_sg  = s_q & (nj == N - 1);
  end

  nibble_mul_4x4 u_nib (
    .a        (nib_a),
    .b        (nib_b),
    .a_signed (a_sg),
    .b_signed (b_sg),
    .p        (pp)
  );

  always_comb begin
    pp_ext = {(2*WIDTH){(a_sg | b_sg) & pp[2*NIBBLE_W-1]}};
    pp_ext[2*NIBBLE_W-1:0] = pp;
    term = pp_ext << (NIBBLE_W * (ni + nj));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = start_state;
      end
      BUSY: begin
        if (k == K_LAST) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) nxt = in_valid ? start_state : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= 1'b0;
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
      s_q <= op_signed;
      acc <= '0;
      k   <= '0;
    end else if (state == BUSY) begin
      acc <= acc + term;
      k   <= (k == K_LAST) ? '0 : k + 1'b1;
    end
  end

  assign product = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_shiftadder_seq_mult.sv
// Scoreboard bench for shiftadder_seq_mult against an arithmetic reference.
// Honours SHIFTADDER_SEQ_EARLY_EXIT_EN for zero-operand latency.
module tb_shiftadder_seq_mult;

  localparam int W  = 8;
  localparam int NN = (W / 4) * (W / 4);
`ifdef SHIFTADDER_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  shiftadder_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_signed (op_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   ov_prev = 1'b0;
  bit   acc_with_retire = 1'b0;
  bit   rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint ra;
    longint rb;
    ra = s ? longint'($signed(a)) : longint'(a);
    rb = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(ra * rb);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else chk("latency", cyc - sb[0].cyc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("product", longint'(product), longint'(e.prod));
      end
      ov_prev = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic s);
    exp_t e;
    bit ok = 1'b0;
    op_a = a;
    op_b = b;
    op_signed = s;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_with_retire = out_valid;
        e.prod = ref_mul(a, b, s);
        e.lat  = (EE && (a == 0 || b == 0)) ? 1 : NN;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    op_signed = 1'($urandom);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] hold;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    op_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_product", longint'(product), 0);
    @(posedge clk);
    #1;

    send(8'h7F, 8'h7F, 1'b1);
    @(negedge clk);
    chk("busy_in_ready", in_ready, 0);
    drain();
    send(8'h80, 8'h80, 1'b1);
    drain();
    send(8'hFF, 8'h01, 1'b1);
    drain();
    send(8'hFF, 8'hFF, 1'b0);
    drain();

    send(8'h12, 8'h34, 1'b0);
    send(8'hA5, 8'h3C, 1'b1);
    chk("retire_accept_same_edge", acc_with_retire, 1);
    drain();

    send(8'h00, 8'h9C, 1'b1);
    drain();

    out_ready = 1'b0;
    send(8'h9B, 8'h47, 1'b1);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    hold = ref_mul(8'h9B, 8'h47, 1'b1);
    for (int t = 0; t < 10; t++) begin
      chk("bp_product", longint'(product), longint'(hold));
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle_valid", out_valid, 0);
    chk("bp_release_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send(8'h5A, 8'h6B, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h03, 8'h05, 1'b0);
    drain();

    rnd_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
